// File: rtl/simd_dmem_dump_reader_pkg.sv
// Shared definitions for the DMEM dump reader: FSM encoding, bus timing and lane sizing.
package simd_dmem_dump_reader_pkg;

  localparam int unsigned STATE_W = 3;

  localparam logic [STATE_W-1:0] ST_IDLE    = 3'd0;
  localparam logic [STATE_W-1:0] ST_READ    = 3'd1;
  localparam logic [STATE_W-1:0] ST_CAPTURE = 3'd2;
  localparam logic [STATE_W-1:0] ST_EMIT    = 3'd3;
  localparam logic [STATE_W-1:0] ST_FIN     = 3'd4;

  // DMEM returns read data the cycle after the request.
  localparam int unsigned READ_LATENCY = 1;

  // Lane index needs at least one bit even for a single-lane (CP) row.
  function automatic int unsigned laneIdxWidth(input int unsigned numLanes);
    return (numLanes > 1) ? $clog2(numLanes) : 1;
  endfunction

endpackage

// File: rtl/simd_dmem_dump_reader_serializer.sv
// Row buffer plus lane counter: presents one lane word at a time on a valid/ready stream.
module simd_dmem_dump_reader_serializer
  import simd_dmem_dump_reader_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_LANES  = 1
) (
  input  logic                            iClk,
  input  logic                            iReset,
  input  logic                            iLoad,
  input  logic                            iAdvance,
  input  logic                            iEmitNext,
  input  logic                            iRowsOne,
  input  logic [NUM_LANES*DATA_WIDTH-1:0] iRow,
  input  logic                            iReady,
  output logic                            oValid,
  output logic [DATA_WIDTH-1:0]           oData,
  output logic                            oLast,
  output logic                            oFire_c,
  output logic                            oLaneLast_c
);

  localparam int unsigned LANE_W = laneIdxWidth(NUM_LANES);

  logic [NUM_LANES*DATA_WIDTH-1:0] rowBuf;
  logic [LANE_W-1:0]               lane;
  logic [LANE_W-1:0]               nextLane;
  logic                            validQ;
  logic [DATA_WIDTH-1:0]           dataQ;
  logic                            lastQ;

  assign nextLane    = lane + LANE_W'(1);
  assign oFire_c     = validQ & iReady;
  assign oLaneLast_c = (lane == LANE_W'(NUM_LANES - 1));

  // Data and Last are re-registered only on load/advance, so they hold while stalled.
  always_ff @(posedge iClk or negedge iReset) begin
    if (!iReset) begin
      rowBuf <= '0;
      lane   <= '0;
      validQ <= 1'b0;
      dataQ  <= '0;
      lastQ  <= 1'b0;
    end else begin
      validQ <= iEmitNext;
      if (iLoad) begin
        rowBuf <= iRow;
        lane   <= '0;
        dataQ  <= iRow[DATA_WIDTH-1:0];
        lastQ  <= iEmitNext && (NUM_LANES == 1) && iRowsOne;
      end else if (iAdvance) begin
        lane   <= nextLane;
        dataQ  <= rowBuf[DATA_WIDTH*nextLane +: DATA_WIDTH];
        lastQ  <= iEmitNext && (nextLane == LANE_W'(NUM_LANES - 1)) && iRowsOne;
      end else if (!iEmitNext) begin
        lastQ  <= 1'b0;
      end
    end
  end

  assign oValid = validQ;
  assign oData  = dataQ;
  assign oLast  = lastQ;

endmodule

// File: rtl/simd_dmem_dump_reader.sv
// DMEM read-back engine: walks a word range over the DMEM bus and streams each row lane by lane.
module simd_dmem_dump_reader
  import simd_dmem_dump_reader_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned NUM_LANES  = 1
) (
  input  logic                            iClk,
  input  logic                            iReset,
  input  logic                            iStart,
  input  logic                            iAbort,
  input  logic [ADDR_WIDTH-3:0]           iBase_Word,
  input  logic [ADDR_WIDTH-2:0]           iWord_Count,
  output logic                            oBusy,
  output logic                            oDone,
  output logic [NUM_LANES-1:0]            oBus_DMEM_Valid,
  output logic [NUM_LANES*ADDR_WIDTH-1:0] oBus_DMEM_Address,
  output logic [NUM_LANES*DATA_WIDTH-1:0] oBus_DMEM_Write_Data,
  output logic [NUM_LANES-1:0]            oBus_DMEM_Write_Enable,
  input  logic [NUM_LANES*DATA_WIDTH-1:0] iBus_DMEM_Read_Data,
  output logic                            oDump_Valid,
  input  logic                            iDump_Ready,
  output logic [DATA_WIDTH-1:0]           oDump_Data,
  output logic                            oDump_Last
);

  localparam int unsigned WORD_W = ADDR_WIDTH - 2;
  localparam int unsigned CNT_W  = ADDR_WIDTH - 1;

  logic [STATE_W-1:0] state;
  logic [STATE_W-1:0] nextState;
  logic [WORD_W-1:0]  wordAddr;
  logic [CNT_W-1:0]   rowsLeft;
  logic               busyQ;
  logic               doneQ;
  logic               busValidQ;
  logic               fire_c;
  logic               laneLast_c;
  logic               rowsOne_c;
  logic               rowDone_c;
  logic               loadRow_c;
  logic               advLane_c;
  logic               emitNext_c;

  assign rowsOne_c = (rowsLeft == CNT_W'(1));

  // Next-state logic; abort from any busy state wins over start and handshake.
  always_comb begin
    nextState = state;
    case (state)
      ST_IDLE:    if (iStart) nextState = (iWord_Count == '0) ? ST_FIN : ST_READ;
      ST_READ:    nextState = ST_CAPTURE;
      ST_CAPTURE: nextState = ST_EMIT;
      ST_EMIT:    if (fire_c && laneLast_c) nextState = rowsOne_c ? ST_FIN : ST_READ;
      ST_FIN:     nextState = ST_IDLE;
      default:    nextState = ST_IDLE;
    endcase
    if (iAbort && (state != ST_IDLE)) nextState = ST_IDLE;
  end

  always_comb begin
    rowDone_c  = 1'b0;
    loadRow_c  = 1'b0;
    advLane_c  = 1'b0;
    emitNext_c = (nextState == ST_EMIT);
    if (!iAbort) begin
      rowDone_c = (state == ST_EMIT) && fire_c && laneLast_c;
      loadRow_c = (state == ST_CAPTURE);
      advLane_c = (state == ST_EMIT) && fire_c && !laneLast_c;
    end
  end

  always_ff @(posedge iClk or negedge iReset) begin
    if (!iReset) state <= ST_IDLE;
    else         state <= nextState;
  end

  // Status/bus outputs are registered from the next state so they line up with it.
  always_ff @(posedge iClk or negedge iReset) begin
    if (!iReset) begin
      busyQ     <= 1'b0;
      doneQ     <= 1'b0;
      busValidQ <= 1'b0;
      wordAddr  <= '0;
      rowsLeft  <= '0;
    end else begin
      busyQ     <= (nextState != ST_IDLE);
      doneQ     <= (nextState == ST_FIN);
      busValidQ <= (nextState == ST_READ);
      if ((state == ST_IDLE) && iStart) begin
        wordAddr <= iBase_Word;
        rowsLeft <= iWord_Count;
      end else if (rowDone_c) begin
        wordAddr <= wordAddr + WORD_W'(1);
        rowsLeft <= rowsLeft - CNT_W'(1);
      end
    end
  end

  simd_dmem_dump_reader_serializer #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_LANES  (NUM_LANES)
  ) uSerializer (
    .iClk        (iClk),
    .iReset      (iReset),
    .iLoad       (loadRow_c),
    .iAdvance    (advLane_c),
    .iEmitNext   (emitNext_c),
    .iRowsOne    (rowsOne_c),
    .iRow        (iBus_DMEM_Read_Data),
    .iReady      (iDump_Ready),
    .oValid      (oDump_Valid),
    .oData       (oDump_Data),
    .oLast       (oDump_Last),
    .oFire_c     (fire_c),
    .oLaneLast_c (laneLast_c)
  );

  assign oBusy                  = busyQ;
  assign oDone                  = doneQ;
  assign oBus_DMEM_Valid        = {NUM_LANES{busValidQ}};
  assign oBus_DMEM_Address      = {NUM_LANES{wordAddr, 2'b00}};
  assign oBus_DMEM_Write_Data   = '0;
  assign oBus_DMEM_Write_Enable = '0;

endmodule

// File: tb/tb_simd_dmem_dump_reader.sv
// Bench for the DMEM dump reader: a CP (1-lane) and a PE (4-lane, 6-bit address) instance.
module tb_simd_dmem_dump_reader;

  localparam int unsigned DW    = 32;
  localparam int unsigned CP_AW = 12;
  localparam int unsigned PE_AW = 6;
  localparam int unsigned PE_N  = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rstN;

  logic              cpStart, cpAbort, cpBusy, cpDone, cpDumpValid, cpReady, cpLast;
  logic [CP_AW-3:0]  cpBase;
  logic [CP_AW-2:0]  cpCount;
  logic [0:0]        cpBusValid, cpWe;
  logic [CP_AW-1:0]  cpBusAddr;
  logic [DW-1:0]     cpWd, cpRd, cpData;

  logic              peStart, peAbort, peBusy, peDone, peDumpValid, peReady, peLast;
  logic [PE_AW-3:0]  peBase;
  logic [PE_AW-2:0]  peCount;
  logic [PE_N-1:0]   peBusValid, peWe;
  logic [PE_N*PE_AW-1:0] peBusAddr;
  logic [PE_N*DW-1:0] peWd, peRd;
  logic [DW-1:0]     peData;

  simd_dmem_dump_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(CP_AW), .NUM_LANES(1)) dutCp (
    .iClk(clk), .iReset(rstN), .iStart(cpStart), .iAbort(cpAbort),
    .iBase_Word(cpBase), .iWord_Count(cpCount), .oBusy(cpBusy), .oDone(cpDone),
    .oBus_DMEM_Valid(cpBusValid), .oBus_DMEM_Address(cpBusAddr),
    .oBus_DMEM_Write_Data(cpWd), .oBus_DMEM_Write_Enable(cpWe),
    .iBus_DMEM_Read_Data(cpRd), .oDump_Valid(cpDumpValid), .iDump_Ready(cpReady),
    .oDump_Data(cpData), .oDump_Last(cpLast));

  simd_dmem_dump_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(PE_AW), .NUM_LANES(PE_N)) dutPe (
    .iClk(clk), .iReset(rstN), .iStart(peStart), .iAbort(peAbort),
    .iBase_Word(peBase), .iWord_Count(peCount), .oBusy(peBusy), .oDone(peDone),
    .oBus_DMEM_Valid(peBusValid), .oBus_DMEM_Address(peBusAddr),
    .oBus_DMEM_Write_Data(peWd), .oBus_DMEM_Write_Enable(peWe),
    .iBus_DMEM_Read_Data(peRd), .oDump_Valid(peDumpValid), .iDump_Ready(peReady),
    .oDump_Data(peData), .oDump_Last(peLast));

  // Memories with one-cycle read latency.
  logic [DW-1:0]      cpMem [1024];
  logic [PE_N*DW-1:0] peMem [16];
  always @(posedge clk) if (cpBusValid[0]) cpRd <= cpMem[cpBusAddr[CP_AW-1:2]];
  always @(posedge clk) if (peBusValid[0]) peRd <= peMem[peBusAddr[PE_AW-1:2]];

  int checks = 0;
  int errors = 0;

  // Observed traffic
  int unsigned  cpAddrQ[$];
  logic [DW:0]  cpStrQ[$];
  int           cpDoneCnt;
  int unsigned  peAddrQ[$];
  logic [DW:0]  peStrQ[$];
  int           peDoneCnt, peStallErr, peBusErr;
  bit           peStallCheckOn, peStalled;
  logic [DW-1:0] peHoldData;
  logic         peHoldLast;
  bit           peRandReady;
  logic         peReadyFix;

  // Expected traffic from the model
  int unsigned  expAddrQ[$];
  logic [DW:0]  expStrQ[$];

  always @(posedge clk) begin
    #1;
    peReady = peRandReady ? 1'($urandom_range(0, 1)) : peReadyFix;
  end

  always @(negedge clk) begin
    if (cpBusValid[0]) cpAddrQ.push_back(32'(cpBusAddr));
    if (cpDumpValid && cpReady) cpStrQ.push_back({cpLast, cpData});
    if (cpDone) cpDoneCnt++;
    if (peBusValid != '0) begin
      peAddrQ.push_back(32'(peBusAddr[PE_AW-1:0]));
      if (peBusValid != {PE_N{1'b1}} || peBusAddr != {PE_N{peBusAddr[PE_AW-1:0]}}) peBusErr++;
    end
    if (peWd != '0 || peWe != '0) peBusErr++;
    if (peDumpValid && peReady) peStrQ.push_back({peLast, peData});
    if (peDone) peDoneCnt++;
    if (peStallCheckOn && peStalled &&
        (!peDumpValid || peData != peHoldData || peLast != peHoldLast)) peStallErr++;
    peStalled  = peDumpValid && !peReady;
    peHoldData = peData;
    peHoldLast = peLast;
  end

  // Reference: rows base..base+cnt-1 modulo 16 words, lanes 0..3, Last on final lane of final row.
  function automatic void pe_expect(input int unsigned base, input int unsigned cnt);
    expAddrQ.delete();
    expStrQ.delete();
    for (int unsigned r = 0; r < cnt; r++) begin
      int unsigned w = (base + r) % 16;
      expAddrQ.push_back(w * 4);
      for (int unsigned l = 0; l < PE_N; l++) begin
        logic [PE_N*DW-1:0] row = peMem[w];
        logic lastBit = (r == cnt - 1) && (l == PE_N - 1);
        expStrQ.push_back({lastBit, row[DW*l +: DW]});
      end
    end
  endfunction

  function automatic void pe_clear();
    peAddrQ.delete();
    peStrQ.delete();
    peDoneCnt  = 0;
    peStallErr = 0;
    peBusErr   = 0;
  endfunction

  task automatic pe_run(input int unsigned base, input int unsigned cnt, output bit ok);
    @(posedge clk); #2;
    peBase  = 4'(base);
    peCount = 5'(cnt);
    peStart = 1'b1;
    @(posedge clk); #2;
    peStart = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (!peBusy) begin ok = 1'b1; break; end
      @(posedge clk); #2;
    end
    repeat (2) @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    rstN = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if ({cpBusy, cpDone, cpBusValid, cpDumpValid, cpLast} !== 5'b0) begin
      errors++; $display("FAIL reset_cp_flags got %b exp 0", {cpBusy, cpDone, cpBusValid, cpDumpValid, cpLast});
    end
    checks++;
    if (cpBusAddr !== '0 || cpData !== '0) begin
      errors++; $display("FAIL reset_cp_addr_data got %h/%h exp 0/0", cpBusAddr, cpData);
    end
    checks++;
    if ({peBusy, peDone, peBusValid, peDumpValid, peLast} !== 8'b0) begin
      errors++; $display("FAIL reset_pe_flags got %b exp 0", {peBusy, peDone, peBusValid, peDumpValid, peLast});
    end
    checks++;
    if (peBusAddr !== '0 || peData !== '0 || peWd !== '0 || peWe !== '0) begin
      errors++; $display("FAIL reset_pe_bus got %h/%h exp 0/0", peBusAddr, peData);
    end
    @(negedge clk);
    rstN = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_cp_basic();
    logic [DW-1:0] a, b, c;
    int cyc;
    a = $urandom; b = $urandom; c = $urandom;
    cpMem[4] = a; cpMem[5] = b; cpMem[6] = c;
    cpAddrQ.delete(); cpStrQ.delete(); cpDoneCnt = 0;
    @(posedge clk); #2;
    cpBase = 10'd4; cpCount = 11'd3; cpStart = 1'b1;
    @(posedge clk); #2;
    cpStart = 1'b0;
    cyc = 0;
    while (!cpDone && cyc < 50) begin @(posedge clk); #2; cyc++; end
    checks++;
    if (cyc != 9) begin errors++; $display("FAIL cp_start_to_done got %0d cycles exp 9", cyc); end
    @(posedge clk); #2;
    checks++;
    if (cpDone !== 1'b0 || cpBusy !== 1'b0) begin
      errors++; $display("FAIL cp_done_width got done=%b busy=%b exp 0/0", cpDone, cpBusy);
    end
    repeat (2) @(posedge clk);
    checks++;
    if (cpAddrQ.size() != 3 || cpAddrQ[0] != 32'h10 || cpAddrQ[1] != 32'h14 || cpAddrQ[2] != 32'h18) begin
      errors++; $display("FAIL cp_addresses got %p exp 10,14,18", cpAddrQ);
    end
    checks++;
    if (cpStrQ.size() != 3 || cpStrQ[0] != {1'b0, a} || cpStrQ[1] != {1'b0, b} || cpStrQ[2] != {1'b1, c}) begin
      errors++; $display("FAIL cp_stream got %p exp %h %h %h(last)", cpStrQ, a, b, c);
    end
    checks++;
    if (cpDoneCnt != 1) begin errors++; $display("FAIL cp_done_count got %0d exp 1", cpDoneCnt); end
  endtask

  task automatic test_pe_stream(input string name, input int unsigned base, input int unsigned cnt, input bit rr);
    bit ok;
    pe_clear();
    pe_expect(base, cnt);
    peRandReady = rr;
    peReadyFix = 1'b1;
    peStallCheckOn = 1'b1;
    pe_run(base, cnt, ok);
    peRandReady = 1'b0;
    checks++;
    if (!ok) begin errors++; $display("FAIL %s timeout busy=%b exp 0", name, peBusy); end
    checks++;
    if (peAddrQ.size() != expAddrQ.size()) begin
      errors++; $display("FAIL %s addr_count got %0d exp %0d", name, peAddrQ.size(), expAddrQ.size());
    end else begin
      foreach (expAddrQ[i]) begin
        checks++;
        if (peAddrQ[i] != expAddrQ[i]) begin
          errors++; $display("FAIL %s addr[%0d] got %h exp %h", name, i, peAddrQ[i], expAddrQ[i]);
        end
      end
    end
    checks++;
    if (peStrQ.size() != expStrQ.size()) begin
      errors++; $display("FAIL %s word_count got %0d exp %0d", name, peStrQ.size(), expStrQ.size());
    end else begin
      foreach (expStrQ[i]) begin
        checks++;
        if (peStrQ[i] !== expStrQ[i]) begin
          errors++; $display("FAIL %s word[%0d] got %h exp %h", name, i, peStrQ[i], expStrQ[i]);
        end
      end
    end
    checks++;
    if (peDoneCnt != 1) begin errors++; $display("FAIL %s done_count got %0d exp 1", name, peDoneCnt); end
    checks++;
    if (peStallErr != 0 || peBusErr != 0) begin
      errors++; $display("FAIL %s stall/bus errors got %0d/%0d exp 0/0", name, peStallErr, peBusErr);
    end
  endtask

  task automatic test_pe_order();
    peMem[0] = {32'd3, 32'd2, 32'd1, 32'd0};
    peMem[1] = {32'd7, 32'd6, 32'd5, 32'd4};
    test_pe_stream("pe_order", 0, 2, 1'b0);
  endtask

  task automatic test_pe_random();
    for (int k = 0; k < 3; k++) test_pe_stream("pe_random", $urandom_range(0, 15), $urandom_range(1, 5), 1'b0);
  endtask

  task automatic test_backpressure();
    for (int k = 0; k < 4; k++) test_pe_stream("backpressure", $urandom_range(0, 15), $urandom_range(1, 6), 1'b1);
  endtask

  task automatic test_wrap();
    test_pe_stream("wrap", 15, 2, 1'b0);
    test_pe_stream("full_range", $urandom_range(0, 15), 16, 1'b1);
  endtask

  task automatic test_zero_count();
    bit ok;
    pe_clear();
    peReadyFix = 1'b1;
    pe_run($urandom_range(0, 15), 0, ok);
    checks++;
    if (!ok || peDoneCnt != 1) begin
      errors++; $display("FAIL zero_count done got %0d ok=%b exp 1", peDoneCnt, ok);
    end
    checks++;
    if (peAddrQ.size() != 0 || peStrQ.size() != 0) begin
      errors++; $display("FAIL zero_count traffic got %0d reads %0d words exp 0/0", peAddrQ.size(), peStrQ.size());
    end
  endtask

  task automatic test_start_while_busy();
    int unsigned b1;
    int n;
    b1 = $urandom_range(0, 15);
    pe_clear();
    pe_expect(b1, 2);
    peReadyFix = 1'b1;
    peStallCheckOn = 1'b1;
    @(posedge clk); #2;
    peBase = 4'(b1); peCount = 5'd2; peStart = 1'b1;
    @(posedge clk); #2;
    peStart = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    peBase = 4'(b1 + 7); peCount = 5'd5; peStart = 1'b1;
    @(posedge clk); #2;
    peStart = 1'b0;
    n = 0;
    while (!peDone && n < 200) begin @(posedge clk); #2; n++; end
    checks++;
    if (!peDone) begin errors++; $display("FAIL busy_start timeout done=%b exp 1", peDone); end
    peBase = 4'(b1 + 3); peCount = 5'd1; peStart = 1'b1;
    @(posedge clk); #2;
    peStart = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (peBusy !== 1'b0 || peDoneCnt != 1) begin
      errors++; $display("FAIL busy_start state got busy=%b done_cnt=%0d exp 0/1", peBusy, peDoneCnt);
    end
    checks++;
    if (peAddrQ.size() != 2 || peAddrQ[0] != expAddrQ[0] || peAddrQ[1] != expAddrQ[1]) begin
      errors++; $display("FAIL busy_start reads got %p exp %p", peAddrQ, expAddrQ);
    end
    checks++;
    if (peStrQ != expStrQ) begin
      errors++; $display("FAIL busy_start stream got %0d words exp %0d", peStrQ.size(), expStrQ.size());
    end
  endtask

  task automatic test_abort_reset();
    int n;
    pe_clear();
    peStallCheckOn = 1'b0;
    peReadyFix = 1'b0;
    @(posedge clk); #2;
    peBase = 4'($urandom_range(0, 15)); peCount = 5'd3; peStart = 1'b1;
    @(posedge clk); #2;
    peStart = 1'b0;
    n = 0;
    while (!peDumpValid && n < 20) begin @(posedge clk); #2; n++; end
    checks++;
    if (!peDumpValid) begin errors++; $display("FAIL abort_reach_emit got valid=%b exp 1", peDumpValid); end
    peAbort = 1'b1; peStart = 1'b1;
    @(posedge clk); #2;
    peAbort = 1'b0; peStart = 1'b0;
    checks++;
    if (peDumpValid !== 1'b0 || peBusy !== 1'b0) begin
      errors++; $display("FAIL abort_drop got valid=%b busy=%b exp 0/0", peDumpValid, peBusy);
    end
    repeat (4) @(posedge clk);
    #2;
    checks++;
    if (peDoneCnt != 0 || peStrQ.size() != 0 || peBusy !== 1'b0) begin
      errors++; $display("FAIL abort_quiet got done=%0d words=%0d busy=%b exp 0/0/0", peDoneCnt, peStrQ.size(), peBusy);
    end
    // Async reset while a read request is on the bus.
    peReadyFix = 1'b1;
    pe_clear();
    @(posedge clk); #2;
    peBase = 4'($urandom_range(0, 15)); peCount = 5'd3; peStart = 1'b1;
    @(posedge clk); #2;
    peStart = 1'b0;
    checks++;
    if (peBusValid !== {PE_N{1'b1}}) begin errors++; $display("FAIL reset_in_read valid got %b exp f", peBusValid); end
    rstN = 1'b0;
    #1;
    checks++;
    if (peBusValid !== '0 || peBusy !== 1'b0 || peDumpValid !== 1'b0 || peBusAddr !== '0) begin
      errors++; $display("FAIL async_reset got valid=%b busy=%b addr=%h exp 0", peBusValid, peBusy, peBusAddr);
    end
    @(negedge clk);
    rstN = 1'b1;
    repeat (6) @(posedge clk);
    #2;
    checks++;
    if (peDoneCnt != 0 || peBusy !== 1'b0) begin
      errors++; $display("FAIL reset_quiet got done=%0d busy=%b exp 0/0", peDoneCnt, peBusy);
    end
    peStallCheckOn = 1'b1;
  endtask

  initial begin
    rstN = 1'b0;
    cpStart = 1'b0; cpAbort = 1'b0; cpBase = '0; cpCount = '0; cpReady = 1'b1; cpRd = '0;
    peStart = 1'b0; peAbort = 1'b0; peBase = '0; peCount = '0; peRd = '0;
    peRandReady = 1'b0; peReadyFix = 1'b1; peReady = 1'b1;
    peStallCheckOn = 1'b0; peStalled = 1'b0; peHoldData = '0; peHoldLast = 1'b0;
    cpDoneCnt = 0;
    pe_clear();
    for (int i = 0; i < 1024; i++) cpMem[i] = $urandom;
    for (int i = 0; i < 16; i++) peMem[i] = {$urandom, $urandom, $urandom, $urandom};

    test_reset();
    test_cp_basic();
    test_pe_order();
    test_pe_random();
    test_backpressure();
    test_wrap();
    test_zero_count();
    test_start_while_busy();
    test_abort_reset();
    test_pe_stream("after_reset", $urandom_range(0, 15), 3, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
